// File: rtl/sync_fifo_buffer.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty thresholds,
// registered read data/valid and sticky overflow/underflow flags.
module sync_fifo_buffer #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned ADDR     = 2,
    parameter int unsigned AF_LEVEL = 3,
    parameter int unsigned AE_LEVEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_en,
    input  logic [WIDTH-1:0] w_data,
    input  logic             r_en,
    output logic [WIDTH-1:0] r_data,
    output logic             r_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ADDR:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    localparam int unsigned DEPTH = 2 ** ADDR;
    localparam logic [ADDR:0] DepthCnt = DEPTH[ADDR:0];
    localparam logic [ADDR:0] AfCnt    = AF_LEVEL[ADDR:0];
    localparam logic [ADDR:0] AeCnt    = AE_LEVEL[ADDR:0];

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR-1:0]  wptr_q, wptr_d;
    logic [ADDR-1:0]  rptr_q, rptr_d;
    logic [ADDR:0]    count_q, count_d;
    logic [WIDTH-1:0] r_data_q, r_data_d;
    logic             r_valid_q, r_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_ok, rd_ok;

    // Status flags come only from the registered count, never from inputs.
    always_comb begin
        full         = (count_q == DepthCnt);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AfCnt);
        almost_empty = (count_q <= AeCnt);
    end

    always_comb begin
        wr_ok = w_en & ~full;
        rd_ok = r_en & ~empty;
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        r_data_d    = r_data_q;
        r_valid_d   = rd_ok;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_ok) begin
            rptr_d   = rptr_q + 1'b1;
            r_data_d = mem_q[rptr_q];
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new error event in the same cycle as err_clr must win.
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (w_en && full) begin
            overflow_d = 1'b1;
        end
        if (r_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            r_data_q    <= '0;
            r_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            r_data_q    <= r_data_d;
            r_valid_q   <= r_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; a write is simply suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst && wr_ok) begin
            mem_q[wptr_q] <= w_data;
        end
    end

    always_comb begin
        r_data    = r_data_q;
        r_valid   = r_valid_q;
        count     = count_q;
        overflow  = overflow_q;
        underflow = underflow_q;
    end

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Directed self-checking bench for sync_fifo_buffer (WIDTH=4, ADDR=2, AF=3, AE=1).
module tb_sync_fifo_buffer;

    logic       clk;
    logic       rst;
    logic       w_en;
    logic [3:0] w_data;
    logic       r_en;
    logic [3:0] r_data;
    logic       r_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    int passed;
    int total;

    sync_fifo_buffer #(
        .WIDTH   (4),
        .ADDR    (2),
        .AF_LEVEL(3),
        .AE_LEVEL(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .w_en        (w_en),
        .w_data      (w_data),
        .r_en        (r_en),
        .r_data      (r_data),
        .r_valid     (r_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        total++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else passed++;
        total++; if (almost_empty !== 1'b1) $display("FAIL reset_ae got %b exp 1", almost_empty); else passed++;
        total++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else passed++;
        total++; if (almost_full !== 1'b0) $display("FAIL reset_af got %b exp 0", almost_full); else passed++;
        total++; if (r_valid !== 1'b0) $display("FAIL reset_rvalid got %b exp 0", r_valid); else passed++;
        total++; if (r_data !== 4'h0) $display("FAIL reset_rdata got %h exp 0", r_data); else passed++;
        total++; if ({overflow, underflow} !== 2'b00)
            $display("FAIL reset_errs got %b exp 00", {overflow, underflow}); else passed++;
    endtask

    task automatic test_fill();
        logic [3:0] d;
        d = 4'hA;
        for (int i = 0; i < 4; i++) begin
            w_en   = 1'b1;
            w_data = d;
            tick();
            d = d + 4'h1;
            total++; if (count !== 3'(i + 1))
                $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); else passed++;
            total++; if (almost_full !== (i >= 2))
                $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, i >= 2); else passed++;
            total++; if (almost_empty !== (i == 0))
                $display("FAIL fill_ae[%0d] got %b exp %b", i, almost_empty, i == 0); else passed++;
            total++; if (full !== (i == 3))
                $display("FAIL fill_full[%0d] got %b exp %b", i, full, i == 3); else passed++;
            total++; if (empty !== 1'b0)
                $display("FAIL fill_empty[%0d] got %b exp 0", i, empty); else passed++;
        end
        w_en = 1'b0;
    endtask

    task automatic test_overflow_drain();
        logic [3:0] d;
        w_en   = 1'b1;
        w_data = 4'hE;
        tick();
        w_en = 1'b0;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", overflow); else passed++;
        total++; if (count !== 3'd4) $display("FAIL ovf_count got %0d exp 4", count); else passed++;
        d    = 4'hA;
        r_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (r_valid !== 1'b1)
                $display("FAIL drain_rvalid[%0d] got %b exp 1", i, r_valid); else passed++;
            total++; if (r_data !== d)
                $display("FAIL drain_rdata[%0d] got %h exp %h", i, r_data, d); else passed++;
            d = d + 4'h1;
        end
        r_en = 1'b0;
        total++; if (empty !== 1'b1) $display("FAIL drain_empty got %b exp 1", empty); else passed++;
        tick();
        total++; if (r_valid !== 1'b0) $display("FAIL idle_rvalid got %b exp 0", r_valid); else passed++;
        total++; if (r_data !== 4'hD) $display("FAIL idle_rdata_hold got %h exp D", r_data); else passed++;
        total++; if (underflow !== 1'b0) $display("FAIL drain_udf got %b exp 0", underflow); else passed++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (overflow !== 1'b0) $display("FAIL ovf_clr got %b exp 0", overflow); else passed++;
    endtask

    task automatic test_back_to_back();
        w_en   = 1'b1;
        w_data = 4'h1;
        r_en   = 1'b0;
        tick();
        for (int i = 1; i < 6; i++) begin
            w_data = 4'(i + 1);
            r_en   = 1'b1;
            tick();
            total++; if (count !== 3'd1)
                $display("FAIL b2b_count[%0d] got %0d exp 1", i, count); else passed++;
            total++; if (r_valid !== 1'b1 || r_data !== 4'(i))
                $display("FAIL b2b_rdata[%0d] got %b/%h exp 1/%h", i, r_valid, r_data, 4'(i));
            else passed++;
        end
        w_en = 1'b0;
        tick();
        r_en = 1'b0;
        total++; if (r_data !== 4'h6 || count !== 3'd0)
            $display("FAIL b2b_last got %h/%0d exp 6/0", r_data, count); else passed++;
    endtask

    task automatic test_underflow();
        r_en   = 1'b1;
        w_en   = 1'b1;
        w_data = 4'h5;
        tick();
        w_en = 1'b0;
        total++; if (underflow !== 1'b1) $display("FAIL udf_set got %b exp 1", underflow); else passed++;
        total++; if (count !== 3'd1) $display("FAIL udf_count got %0d exp 1", count); else passed++;
        total++; if (r_valid !== 1'b0) $display("FAIL udf_rvalid got %b exp 0", r_valid); else passed++;
        tick();
        r_en = 1'b0;
        total++; if (r_valid !== 1'b1 || r_data !== 4'h5)
            $display("FAIL udf_read got %b/%h exp 1/5", r_valid, r_data); else passed++;
    endtask

    task automatic test_mid_reset_errclr();
        w_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            w_data = 4'(i + 7);
            tick();
        end
        w_en = 1'b0;
        total++; if (count !== 3'd2) $display("FAIL pre_rst_count got %0d exp 2", count); else passed++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++; if (count !== 3'd0 || empty !== 1'b1)
            $display("FAIL mid_rst got %0d/%b exp 0/1", count, empty); else passed++;
        total++; if (underflow !== 1'b0) $display("FAIL mid_rst_udf got %b exp 0", underflow); else passed++;
        w_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w_data = 4'(i);
            tick();
        end
        total++; if (overflow !== 1'b1) $display("FAIL ovf2_set got %b exp 1", overflow); else passed++;
        // Set condition and clear in the same cycle: set wins.
        err_clr = 1'b1;
        tick();
        w_en = 1'b0;
        total++; if (overflow !== 1'b1) $display("FAIL set_wins got %b exp 1", overflow); else passed++;
        tick();
        err_clr = 1'b0;
        total++; if (overflow !== 1'b0) $display("FAIL errclr got %b exp 0", overflow); else passed++;
        total++; if (count !== 3'd4) $display("FAIL ovf2_count got %0d exp 4", count); else passed++;
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        rst     = 1'b0;
        w_en    = 1'b0;
        w_data  = 4'h0;
        r_en    = 1'b0;
        err_clr = 1'b0;
        #1;
        test_reset();
        test_fill();
        test_overflow_drain();
        test_back_to_back();
        test_underflow();
        test_mid_reset_errclr();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
